// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and counter limits for the memory-stage controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, HOLD = 2'b10} state_e;
  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable-driven up counter that sticks at its all-ones value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: XM-to-MW memory stage, handshakes with a variable-latency data memory
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] XM_aluOut,
  input  logic [DATA_W-1:0] XM_writeData,
  input  logic              XM_memRead,
  input  logic              XM_memWrite,
  input  logic              XM_halt,
  input  logic              XM_flush,
  input  logic              ext_stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_createdump,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_stall,
  output logic [DATA_W-1:0] readData,
  output logic              align_err_m,
  output logic              stall_m,
  output logic [CNT_W-1:0]  stall_cycles
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic acc, mis, rd, req, dump, unused_ok;
  assign acc       = (XM_memRead | XM_memWrite) & ~XM_flush;
  assign mis       = acc & XM_aluOut[0];
  assign rd        = XM_memRead & ~XM_memWrite;
  assign mem_addr  = XM_aluOut;
  assign mem_wdata = XM_writeData;
  // the request is held through BUSY regardless of mem_stall, so it only matters to the memory
  assign unused_ok = mem_stall;
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    readData    = hold_q;
    stall_m     = 1'b0;
    req         = 1'b0;
    align_err_m = 1'b0;
    dump        = 1'b0;
    case (state_q)
      IDLE: begin
        align_err_m = mis;
        req         = acc & ~mis & ~ext_stall;
        readData    = (req && mem_done) ? mem_rdata : hold_q;
        hold_d      = (req && mem_done && rd) ? mem_rdata : hold_q;
        stall_m     = req & ~mem_done;
        state_d     = (req && !mem_done) ? BUSY : IDLE;
        dump        = XM_halt & ~XM_flush & ~stall_m & ~ext_stall;
      end
      BUSY: begin
        req      = 1'b1;
        stall_m  = ~mem_done | ext_stall;
        readData = mem_done ? mem_rdata : hold_q;
        hold_d   = (mem_done && (rd || ext_stall)) ? mem_rdata : hold_q;
        state_d  = !mem_done ? BUSY : ext_stall ? HOLD : IDLE;
      end
      HOLD:    state_d = ext_stall ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign mem_rd         = req & rd & ~rst;
  assign mem_wr         = req & XM_memWrite & ~rst;
  assign mem_createdump = dump & ~rst;
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    hold_q  <= rst ? '0 : hold_d;
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (stall_m),
    .cnt_o (stall_cycles)
  );
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller, between the XM pipeline register and the MW pipeline register.
- Turns XM load/store requests into a handshake with a variable-latency data memory (cache or stall-memory).
- Detects misaligned word accesses and freezes the upstream pipe while an access is outstanding.
- Drives readData and align_err_m, which MW captures.

Parameters:
DATA_W, 16, data and address width
CNT_W, 16, width of the saturating memory-stall cycle counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
XM_aluOut  in  DATA_W  effective address
XM_writeData  in  DATA_W  store data
XM_memRead  in  1  load request
XM_memWrite  in  1  store request
XM_halt  in  1  HALT instruction in stage
XM_flush  in  1  instruction in stage is squashed
ext_stall  in  1  pipe frozen by another stage (e.g. fetch memory stall)
mem_addr  out  DATA_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_createdump  out  1  memory dump request
mem_rdata  in  DATA_W  memory read data, valid when mem_done
mem_done  in  1  access complete this cycle
mem_stall  in  1  memory busy, request must be held
readData  out  DATA_W  load result to MW
align_err_m  out  1  misaligned access flag to MW
stall_m  out  1  freeze PC/FD/DX/XM and hold MW input
stall_cycles  out  CNT_W  saturating count of cycles with stall_m=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - state<=IDLE; data_hold<=0; stall_cycles<=0.
  - All request outputs 0 during reset. Outstanding memory access is abandoned; the memory is reset by the same rst.
- acc = (XM_memRead|XM_memWrite) & ~XM_flush. mis = acc & XM_aluOut[0].
- align_err_m = mis (combinational, IDLE only). A misaligned access issues no request and causes no stall.
- mem_addr = XM_aluOut and mem_wdata = XM_writeData at all times. XM is frozen while BUSY/HOLD, so both stay stable.
- States:
  - IDLE:
    - If acc & ~mis & ~ext_stall: assert mem_rd/mem_wr (matching the request) this cycle.
    - If mem_done the same cycle (zero-wait hit): readData=mem_rdata, stall_m=0, stay IDLE, data_hold<=mem_rdata on a read.
    - Otherwise: stall_m=1, go to BUSY.
    - If acc & ext_stall: no request is issued and the stage waits in IDLE.
  - BUSY:
    - Hold mem_rd/mem_wr high while the access is outstanding (covers mem_stall=1). stall_m=1.
    - On mem_done with ext_stall=0: readData=mem_rdata, stall_m=0, data_hold<=mem_rdata on a read, go to IDLE.
    - On mem_done with ext_stall=1: data_hold<=mem_rdata, go to HOLD; requests drop next cycle.
  - HOLD:
    - No request. readData=data_hold, stall_m=1 only through ext_stall (own stall_m=0).
    - When ext_stall=0: go to IDLE that cycle. MW captures data_hold at that edge.
    - No reissue of the completed access.
- readData outside done/HOLD cycles = data_hold (last load value, 0 after reset). For stores readData is don't-care; the implementation drives data_hold.
- XM_flush is sampled only in IDLE and ignored in BUSY/HOLD, since a frozen instruction cannot be squashed.
- mem_createdump = XM_halt & ~XM_flush & ~stall_m & ~ext_stall, in IDLE only; one pulse per HALT.
- mem_rd and mem_wr are never both 1. If both XM_memRead and XM_memWrite are set, the write wins.
- mem_done while IDLE with no request is ignored.
- stall_cycles increments each cycle stall_m=1 and saturates at 2^CNT_W-1.

Decomposition:
- Package mem_ctrl_pkg: state typedef (IDLE=2'b00, BUSY=2'b01, HOLD=2'b10) and the saturating counter max constant.
- One sub-module: sat_counter (CNT_W, synchronous reset, enable, saturate). The FSM and datapath live in mem_stage_ctrl.

Test Plan:
- Zero-wait load: load 0x0010, mem_done same cycle, rdata 0xBEEF -> readData=0xBEEF, stall_m never 1, state stays IDLE, stall_cycles=0.
- 3-cycle store: store 0x0020 with data 0x1234, mem_stall=1 for 2 cycles then mem_done -> mem_wr high for 3 cycles, stall_m=1 for 2 cycles, stall_cycles=2.
- Misaligned load 0x0013 -> align_err_m=1, mem_rd=0, stall_m=0. Same address with XM_flush=1 -> align_err_m=0.
- Done under ext_stall: load completes with rdata 0xA5A5 while ext_stall=1, ext_stall held 3 more cycles -> state HOLD, readData=0xA5A5, no second mem_rd, IDLE on the cycle ext_stall drops.
- Reset mid-BUSY: rst=1 after 1 stall cycle -> next cycle mem_rd=0, stall_m=0, readData=0, stall_cycles=0.
- HALT: XM_halt=1 held 2 cycles with the pipe unstalled -> mem_createdump=1 in each unstalled cycle. Same with ext_stall=1 -> mem_createdump=0.
